// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU blocks: rounding modes, flag layout,
// sequencer states and the canonical quiet-NaN encoding.
package fpu_pkg;

    typedef enum logic [1:0] {
        RM_RNE = 2'd0,
        RM_RTZ = 2'd1,
        RM_RUP = 2'd2,
        RM_RDN = 2'd3
    } rnd_mode_e;

    localparam int unsigned FLAG_W  = 4;
    localparam int unsigned FLAG_NX = 0;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_NV = 3;

    // Field order matches FLAG_* bit indices: {NV, OF, UF, NX}
    typedef struct packed {
        logic nv;
        logic of;
        logic uf;
        logic nx;
    } fpu_flags_t;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        UNPACK  = 4'd1,
        SPECIAL = 4'd2,
        NORM_A  = 4'd3,
        NORM_B  = 4'd4,
        MULT    = 4'd5,
        SPLIT   = 4'd6,
        NORM_1  = 4'd7,
        NORM_2  = 4'd8,
        ROUND   = 4'd9,
        PACK    = 4'd10,
        OUT     = 4'd11
    } fpu_state_e;

    // Sign 1, exponent all ones, mantissa MSB set; caller truncates to W
    function automatic logic [63:0] canon_nan(input int unsigned exp_w,
                                              input int unsigned man_w);
        return (64'(1) << (exp_w + man_w))
             | (((64'(1) << exp_w) - 64'(1)) << man_w)
             | (64'(1) << (man_w - 1));
    endfunction

endpackage

// File: rtl/fpu_round.sv
// Rounding decision and overflow-result selection, shared by FPU datapaths.
module fpu_round
    import fpu_pkg::*;
(
    input  logic [1:0] rnd_mode,
    input  logic       sign,
    input  logic       lsb,
    input  logic       guard,
    input  logic       rnd,
    input  logic       sticky,
    output logic       inc_c,
    output logic       ovf_inf_c
);

    logic w_inexact;

    assign w_inexact = guard | rnd | sticky;

    // ovf_inf_c: 1 -> overflow returns infinity, 0 -> largest finite
    always_comb begin
        inc_c     = 1'b0;
        ovf_inf_c = 1'b1;
        case (rnd_mode_e'(rnd_mode))
            RM_RNE: begin
                inc_c     = guard & (rnd | sticky | lsb);
                ovf_inf_c = 1'b1;
            end
            RM_RTZ: begin
                inc_c     = 1'b0;
                ovf_inf_c = 1'b0;
            end
            RM_RUP: begin
                inc_c     = w_inexact & ~sign;
                ovf_inf_c = ~sign;
            end
            RM_RDN: begin
                inc_c     = w_inexact & sign;
                ovf_inf_c = sign;
            end
            default: begin
                inc_c     = 1'b0;
                ovf_inf_c = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fpu_mul_param.sv
// Multi-cycle IEEE-754 multiplier, parameterised exponent/mantissa widths,
// one normalisation shift per cycle, four rounding modes.
module fpu_mul_param
    import fpu_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1+EXP_W+MAN_W-1:0]     din1,
    input  logic [1+EXP_W+MAN_W-1:0]     din2,
    input  logic                         valid,
    input  logic [1:0]                   rnd_mode,
    output logic                         busy,
    output logic [1+EXP_W+MAN_W-1:0]     result,
    output logic [FLAG_W-1:0]            flags,
    output logic                         ready
);

    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    localparam int unsigned XW = EXP_W + 2;
    localparam int unsigned FW = MAN_W + 1;
    localparam int unsigned PW = 2 * FW;
    localparam int          BIAS = (1 << (EXP_W - 1)) - 1;

    localparam logic signed [XW-1:0] BIAS_X = XW'(BIAS);
    localparam logic signed [XW-1:0] EMAX   = XW'(BIAS);
    localparam logic signed [XW-1:0] EMIN   = XW'(1 - BIAS);
    localparam logic signed [XW-1:0] ONE_X  = XW'(1);
    localparam logic [W-1:0]         QNAN   = W'(canon_nan(EXP_W, MAN_W));

    fpu_state_e r_state, w_state_n;

    logic [W-1:0]           r_a, r_b;
    logic [1:0]             r_rm;
    logic                   r_sign;
    logic signed [XW-1:0]   r_exp_a, r_exp_b, r_exp;
    logic [FW-1:0]          r_man_a, r_man_b, r_man;
    logic [PW-1:0]          r_prod;
    logic                   r_sticky, r_tiny, r_nx, r_uf;
    logic [W-1:0]           r_pend_res;
    fpu_flags_t             r_pend_flags;

    // Operand classification
    logic [EXP_W-1:0] w_fa, w_fb;
    logic [MAN_W-1:0] w_ma, w_mb;
    logic w_a_emax, w_b_emax, w_a_ezero, w_b_ezero;
    logic w_a_nan, w_b_nan, w_a_snan, w_b_snan;
    logic w_a_inf, w_b_inf, w_a_zero, w_b_zero;

    assign w_fa      = r_a[W-2 -: EXP_W];
    assign w_fb      = r_b[W-2 -: EXP_W];
    assign w_ma      = r_a[MAN_W-1:0];
    assign w_mb      = r_b[MAN_W-1:0];
    assign w_a_emax  = &w_fa;
    assign w_b_emax  = &w_fb;
    assign w_a_ezero = ~|w_fa;
    assign w_b_ezero = ~|w_fb;
    assign w_a_nan   = w_a_emax & (|w_ma);
    assign w_b_nan   = w_b_emax & (|w_mb);
    assign w_a_snan  = w_a_nan & ~w_ma[MAN_W-1];
    assign w_b_snan  = w_b_nan & ~w_mb[MAN_W-1];
    assign w_a_inf   = w_a_emax & ~(|w_ma);
    assign w_b_inf   = w_b_emax & ~(|w_mb);
    assign w_a_zero  = w_a_ezero & ~(|w_ma);
    assign w_b_zero  = w_b_ezero & ~(|w_mb);

    logic w_special;
    logic [W-1:0] w_spec_res;
    fpu_flags_t   w_spec_flags;

    always_comb begin
        w_special    = w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;
        w_spec_flags = '0;
        w_spec_res   = {r_sign, {(W-1){1'b0}}};
        if (w_a_nan | w_b_nan) begin
            w_spec_res      = QNAN;
            w_spec_flags.nv = w_a_snan | w_b_snan;
        end else if ((w_a_inf & w_b_zero) | (w_b_inf & w_a_zero)) begin
            w_spec_res      = QNAN;
            w_spec_flags.nv = 1'b1;
        end else if (w_a_inf | w_b_inf) begin
            w_spec_res = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    // Rounding window: kept mantissa, guard, round, sticky
    logic [FW-1:0] w_man;
    logic          w_g, w_r, w_s;
    logic          w_inc, w_ovf_inf;
    logic [FW:0]   w_man_sum;

    assign w_man     = r_prod[PW-1 -: FW];
    assign w_g       = r_prod[PW-FW-1];
    assign w_r       = r_prod[PW-FW-2];
    assign w_s       = (|r_prod[PW-FW-3:0]) | r_sticky;
    assign w_man_sum = {1'b0, w_man} + (FW+1)'(w_inc);

    fpu_round u_round (
        .rnd_mode  (r_rm),
        .sign      (r_sign),
        .lsb       (w_man[0]),
        .guard     (w_g),
        .rnd       (w_r),
        .sticky    (w_s),
        .inc_c     (w_inc),
        .ovf_inf_c (w_ovf_inf)
    );

    logic [EXP_W-1:0] w_fld;
    logic [W-1:0]     w_pack_res;
    fpu_flags_t       w_pack_flags;

    // Subnormal results (hidden bit clear at emin) pack with exponent field 0
    always_comb begin
        w_pack_flags    = '0;
        w_fld           = r_man[FW-1] ? EXP_W'(r_exp + BIAS_X) : '0;
        w_pack_res      = {r_sign, w_fld, r_man[MAN_W-1:0]};
        w_pack_flags.uf = r_uf;
        w_pack_flags.nx = r_nx;
        if (r_exp > EMAX) begin
            w_pack_flags.of = 1'b1;
            w_pack_flags.nx = 1'b1;
            w_pack_flags.uf = 1'b0;
            w_pack_res = w_ovf_inf ? {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                                   : {r_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            IDLE:    if (valid) w_state_n = UNPACK;
            UNPACK:  w_state_n = SPECIAL;
            SPECIAL: w_state_n = w_special ? OUT : NORM_A;
            NORM_A:  if (r_man_a[FW-1]) w_state_n = NORM_B;
            NORM_B:  if (r_man_b[FW-1]) w_state_n = MULT;
            MULT:    w_state_n = SPLIT;
            SPLIT:   w_state_n = NORM_1;
            NORM_1:  if (r_prod[PW-1]) w_state_n = NORM_2;
            NORM_2:  if (!(r_exp < EMIN)) w_state_n = ROUND;
            ROUND:   w_state_n = PACK;
            PACK:    w_state_n = OUT;
            OUT:     w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    // Datapath; no reset needed, nothing here reaches the ports directly
    always_ff @(posedge clk) begin
        case (r_state)
            IDLE: begin
                if (valid) begin
                    r_a  <= din1;
                    r_b  <= din2;
                    r_rm <= rnd_mode;
                end
            end
            UNPACK: begin
                r_sign  <= r_a[W-1] ^ r_b[W-1];
                r_exp_a <= w_a_ezero ? EMIN : $signed({2'b00, w_fa}) - BIAS_X;
                r_exp_b <= w_b_ezero ? EMIN : $signed({2'b00, w_fb}) - BIAS_X;
                r_man_a <= {~w_a_ezero, w_ma};
                r_man_b <= {~w_b_ezero, w_mb};
            end
            SPECIAL: begin
                r_pend_res   <= w_spec_res;
                r_pend_flags <= w_spec_flags;
            end
            NORM_A: begin
                if (!r_man_a[FW-1]) begin
                    r_man_a <= r_man_a << 1;
                    r_exp_a <= r_exp_a - ONE_X;
                end
            end
            NORM_B: begin
                if (!r_man_b[FW-1]) begin
                    r_man_b <= r_man_b << 1;
                    r_exp_b <= r_exp_b - ONE_X;
                end
            end
            MULT: begin
                r_prod   <= PW'(r_man_a) * PW'(r_man_b);
                r_exp    <= r_exp_a + r_exp_b;
                r_sticky <= 1'b0;
                r_tiny   <= 1'b0;
            end
            SPLIT: begin
                // Product of two [1,2) mantissas lies in [1,4): align MSB
                if (r_prod[PW-1]) r_exp  <= r_exp + ONE_X;
                else              r_prod <= r_prod << 1;
            end
            NORM_1: begin
                if (!r_prod[PW-1]) begin
                    r_prod <= r_prod << 1;
                    r_exp  <= r_exp - ONE_X;
                end
            end
            NORM_2: begin
                if (r_exp < EMIN) begin
                    r_prod   <= r_prod >> 1;
                    r_sticky <= r_sticky | r_prod[0];
                    r_exp    <= r_exp + ONE_X;
                    r_tiny   <= 1'b1;
                end
            end
            ROUND: begin
                if (w_man_sum[FW]) begin
                    r_man <= w_man_sum[FW:1];
                    r_exp <= r_exp + ONE_X;
                end else begin
                    r_man <= w_man_sum[FW-1:0];
                end
                r_nx <= w_g | w_r | w_s;
                r_uf <= r_tiny & (w_g | w_r | w_s);
            end
            PACK: begin
                r_pend_res   <= w_pack_res;
                r_pend_flags <= w_pack_flags;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= 1'b0;
            ready  <= 1'b0;
            result <= '0;
            flags  <= '0;
        end else begin
            busy  <= (w_state_n != IDLE);
            ready <= (r_state == OUT);
            if (r_state == OUT) begin
                result <= r_pend_res;
                flags  <= r_pend_flags;
            end
        end
    end

endmodule

// File: tb/tb_fpu_mul_param.sv
// Directed-vector bench for fpu_mul_param (single precision and a 5/10 half instance).
module tb_fpu_mul_param;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] din1, din2, result;
    logic        valid, busy, ready;
    logic [1:0]  rnd_mode;
    logic [3:0]  flags;

    logic [15:0] h_din1, h_din2, h_result;
    logic        h_valid, h_busy, h_ready;
    logic [1:0]  h_rnd_mode;
    logic [3:0]  h_flags;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fpu_mul_param u_dut (
        .clk(clk), .reset(reset), .din1(din1), .din2(din2), .valid(valid),
        .rnd_mode(rnd_mode), .busy(busy), .result(result), .flags(flags), .ready(ready)
    );

    fpu_mul_param #(.EXP_W(5), .MAN_W(10)) u_half (
        .clk(clk), .reset(reset), .din1(h_din1), .din2(h_din2), .valid(h_valid),
        .rnd_mode(h_rnd_mode), .busy(h_busy), .result(h_result), .flags(h_flags), .ready(h_ready)
    );

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                          output logic [31:0] res, output logic [3:0] fl, output int lat);
        @(negedge clk);
        din1 = a; din2 = b; rnd_mode = m; valid = 1'b1;
        @(posedge clk);
        lat = 1;
        #1 valid = 1'b0;
        while (!ready && lat < 300) begin
            @(posedge clk);
            lat++;
            #1;
        end
        if (!ready) begin
            n_vec++; n_err++;
            $display("FAIL timeout %h*%h: no ready after %0d edges", a, b, lat);
        end
        res = result; fl = flags;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b0)   begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_vec++; if (ready !== 1'b0)  begin n_err++; $display("FAIL reset_ready got %b exp 0", ready); end
        n_vec++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result got %h exp 0", result); end
        n_vec++; if (flags !== 4'h0)  begin n_err++; $display("FAIL reset_flags got %h exp 0", flags); end
        n_vec++; if (h_result !== 16'h0) begin n_err++; $display("FAIL reset_h_result got %h exp 0", h_result); end
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_rne_basic();
        logic [31:0] r; logic [3:0] f; int lat;
        run_op(32'h3FC00000, 32'h40000000, 2'd0, r, f, lat);
        n_vec++; if (r !== 32'h40400000) begin n_err++; $display("FAIL basic_result got %h exp 40400000", r); end
        n_vec++; if (f !== 4'h0)  begin n_err++; $display("FAIL basic_flags got %h exp 0", f); end
        n_vec++; if (lat !== 12)  begin n_err++; $display("FAIL basic_latency got %0d exp 12", lat); end
    endtask

    task automatic test_specials();
        logic [31:0] r; logic [3:0] f; int lat;
        run_op(32'h7F800000, 32'h00000000, 2'd0, r, f, lat);
        n_vec++; if (r !== 32'hFFC00000) begin n_err++; $display("FAIL inf_x_zero_result got %h exp ffc00000", r); end
        n_vec++; if (f !== 4'b1000) begin n_err++; $display("FAIL inf_x_zero_flags got %b exp 1000", f); end
        n_vec++; if (lat !== 4)    begin n_err++; $display("FAIL inf_x_zero_latency got %0d exp 4", lat); end
        run_op(32'h7FA00000, 32'h3F800000, 2'd0, r, f, lat);
        n_vec++; if (r !== 32'hFFC00000) begin n_err++; $display("FAIL snan_result got %h exp ffc00000", r); end
        n_vec++; if (f !== 4'b1000) begin n_err++; $display("FAIL snan_flags got %b exp 1000", f); end
        n_vec++; if (lat !== 4)    begin n_err++; $display("FAIL snan_latency got %0d exp 4", lat); end
        run_op(32'hFF800000, 32'h40000000, 2'd0, r, f, lat);
        n_vec++; if (r !== 32'hFF800000) begin n_err++; $display("FAIL inf_x_fin_result got %h exp ff800000", r); end
        n_vec++; if (f !== 4'b0000) begin n_err++; $display("FAIL inf_x_fin_flags got %b exp 0000", f); end
        run_op(32'h80000000, 32'h40000000, 2'd0, r, f, lat);
        n_vec++; if (r !== 32'h80000000) begin n_err++; $display("FAIL zero_x_fin_result got %h exp 80000000", r); end
    endtask

    task automatic test_overflow();
        logic [31:0] va [4]; logic [1:0] vm [4]; logic [31:0] ve [4];
        logic [31:0] r; logic [3:0] f; int lat;
        va[0] = 32'h7F7FFFFF; vm[0] = 2'd0; ve[0] = 32'h7F800000;
        va[1] = 32'h7F7FFFFF; vm[1] = 2'd1; ve[1] = 32'h7F7FFFFF;
        va[2] = 32'hFF7FFFFF; vm[2] = 2'd2; ve[2] = 32'hFF7FFFFF;
        va[3] = 32'hFF7FFFFF; vm[3] = 2'd3; ve[3] = 32'hFF800000;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], 32'h40000000, vm[i], r, f, lat);
            n_vec++; if (r !== ve[i]) begin n_err++; $display("FAIL ovf%0d_result got %h exp %h", i, r, ve[i]); end
            n_vec++; if (f !== 4'b0101) begin n_err++; $display("FAIL ovf%0d_flags got %b exp 0101", i, f); end
        end
    endtask

    task automatic test_underflow();
        logic [31:0] r; logic [3:0] f; int lat;
        run_op(32'h00800000, 32'h3F000000, 2'd0, r, f, lat);
        n_vec++; if (r !== 32'h00400000) begin n_err++; $display("FAIL sub_exact_result got %h exp 00400000", r); end
        n_vec++; if (f !== 4'b0000) begin n_err++; $display("FAIL sub_exact_flags got %b exp 0000", f); end
        n_vec++; if (lat !== 13)    begin n_err++; $display("FAIL sub_exact_latency got %0d exp 13", lat); end
        run_op(32'h00000001, 32'h3F000000, 2'd0, r, f, lat);
        n_vec++; if (r !== 32'h00000000) begin n_err++; $display("FAIL sub_tiny_result got %h exp 00000000", r); end
        n_vec++; if (f !== 4'b0011) begin n_err++; $display("FAIL sub_tiny_flags got %b exp 0011", f); end
        n_vec++; if (lat !== 59)    begin n_err++; $display("FAIL sub_tiny_latency got %0d exp 59", lat); end
    endtask

    task automatic test_rounding();
        logic [31:0] va [8]; logic [31:0] vb [8]; logic [1:0] vm [8]; logic [31:0] ve [8];
        logic [31:0] r; logic [3:0] f; int lat;
        va[0] = 32'h3F800001; vb[0] = 32'h3F800001; vm[0] = 2'd0; ve[0] = 32'h3F800002;
        va[1] = 32'h3F800001; vb[1] = 32'h3F800001; vm[1] = 2'd2; ve[1] = 32'h3F800003;
        va[2] = 32'h3F800001; vb[2] = 32'h3F800001; vm[2] = 2'd1; ve[2] = 32'h3F800002;
        va[3] = 32'hBF800001; vb[3] = 32'h3F800001; vm[3] = 2'd3; ve[3] = 32'hBF800003;
        va[4] = 32'hBF800001; vb[4] = 32'h3F800001; vm[4] = 2'd2; ve[4] = 32'hBF800002;
        va[5] = 32'h3F800001; vb[5] = 32'h3FC00000; vm[5] = 2'd0; ve[5] = 32'h3FC00002;
        va[6] = 32'h3F800003; vb[6] = 32'h3FC00000; vm[6] = 2'd0; ve[6] = 32'h3FC00004;
        va[7] = 32'h3F800001; vb[7] = 32'h3FC00000; vm[7] = 2'd1; ve[7] = 32'h3FC00001;
        for (int i = 0; i < 8; i++) begin
            run_op(va[i], vb[i], vm[i], r, f, lat);
            n_vec++; if (r !== ve[i]) begin n_err++; $display("FAIL rnd%0d_result got %h exp %h", i, r, ve[i]); end
            n_vec++; if (f !== 4'b0001) begin n_err++; $display("FAIL rnd%0d_flags got %b exp 0001", i, f); end
        end
    endtask

    task automatic test_half();
        int lat;
        @(negedge clk);
        h_din1 = 16'h3C00; h_din2 = 16'hC000; h_rnd_mode = 2'd0; h_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        #1 h_valid = 1'b0;
        while (!h_ready && lat < 300) begin
            @(posedge clk);
            lat++;
            #1;
        end
        n_vec++; if (h_result !== 16'hC000) begin n_err++; $display("FAIL half_result got %h exp c000", h_result); end
        n_vec++; if (h_flags !== 4'h0) begin n_err++; $display("FAIL half_flags got %h exp 0", h_flags); end
        n_vec++; if (lat !== 12) begin n_err++; $display("FAIL half_latency got %0d exp 12", lat); end
    endtask

    task automatic test_ignore_busy();
        int lat;
        @(negedge clk);
        din1 = 32'h3FC00000; din2 = 32'h40000000; rnd_mode = 2'd0; valid = 1'b1;
        @(posedge clk);
        lat = 1;
        #1 din1 = 32'h40000000;
        repeat (4) begin @(posedge clk); lat++; end
        #1 valid = 1'b0;
        while (!ready && lat < 300) begin
            @(posedge clk);
            lat++;
            #1;
        end
        n_vec++; if (result !== 32'h40400000) begin n_err++; $display("FAIL ignore_result got %h exp 40400000", result); end
        n_vec++; if (lat !== 12) begin n_err++; $display("FAIL ignore_latency got %0d exp 12", lat); end
        @(posedge clk); #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_no_queue busy got %b exp 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; logic [3:0] f; int lat;
        run_op(32'h3F800000, 32'h40400000, 2'd0, r, f, lat);
        n_vec++; if (r !== 32'h40400000) begin n_err++; $display("FAIL b2b_first got %h exp 40400000", r); end
        // ready is high now: present the next request in this same cycle
        din1 = 32'h40000000; din2 = 32'h40000000; valid = 1'b1;
        @(posedge clk);
        lat = 1;
        #1 valid = 1'b0;
        while (!ready && lat < 300) begin
            @(posedge clk);
            lat++;
            #1;
        end
        n_vec++; if (result !== 32'h40800000) begin n_err++; $display("FAIL b2b_second got %h exp 40800000", result); end
        n_vec++; if (lat !== 12) begin n_err++; $display("FAIL b2b_latency got %0d exp 12", lat); end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] r; logic [3:0] f; int lat;
        @(negedge clk);
        din1 = 32'h3FC00000; din2 = 32'h40000000; rnd_mode = 2'd0; valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_pre_busy got %b exp 1", busy); end
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (busy !== 1'b0)   begin n_err++; $display("FAIL midrst_busy got %b exp 0", busy); end
        n_vec++; if (ready !== 1'b0)  begin n_err++; $display("FAIL midrst_ready got %b exp 0", ready); end
        n_vec++; if (result !== 32'h0) begin n_err++; $display("FAIL midrst_result got %h exp 0", result); end
        n_vec++; if (flags !== 4'h0)  begin n_err++; $display("FAIL midrst_flags got %h exp 0", flags); end
        @(negedge clk) reset = 1'b0;
        run_op(32'h3F800000, 32'h40400000, 2'd0, r, f, lat);
        n_vec++; if (r !== 32'h40400000) begin n_err++; $display("FAIL midrst_after got %h exp 40400000", r); end
        n_vec++; if (lat !== 12) begin n_err++; $display("FAIL midrst_after_latency got %0d exp 12", lat); end
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; din1 = '0; din2 = '0; rnd_mode = 2'd0;
        h_valid = 1'b0; h_din1 = '0; h_din2 = '0; h_rnd_mode = 2'd0;
        test_reset();
        test_rne_basic();
        test_specials();
        test_overflow();
        test_underflow();
        test_rounding();
        test_half();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
